// File: rtl/button_cmd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// button_ctrl_pkg : shared types and constants for the button command arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package button_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int              DROP_W   = 8;
  localparam logic [DROP_W-1:0] DROP_SAT = 8'd255;

  // cmd_id width; never collapses to zero bits
  function automatic int id_width(input int num_btn);
    return (num_btn > 1) ? $clog2(num_btn) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// button_cmd_arbiter_if : button pulses in, command handshake and status out
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface button_cmd_arbiter_if #(
  parameter int NUM_BTN = 4
);
  import button_ctrl_pkg::*;

  localparam int ID_W = id_width(NUM_BTN);

  logic [NUM_BTN-1:0] btn_pulse;
  logic               cmd_valid;
  logic [ID_W-1:0]    cmd_id;
  logic               cmd_ready;
  logic               op_done;
  logic               busy;
  logic               timeout_err;
  logic [DROP_W-1:0]  drop_cnt;

  modport slave (
    input  btn_pulse, cmd_ready, op_done,
    output cmd_valid, cmd_id, busy, timeout_err, drop_cnt
  );

  modport master (
    output btn_pulse, cmd_ready, op_done,
    input  cmd_valid, cmd_id, busy, timeout_err, drop_cnt
  );

endinterface

`default_nettype wire

// File: rtl/button_cmd_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick starting after last_grant
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import button_ctrl_pkg::*;
#(
  parameter int NUM_BTN = 4,
  parameter int ID_W    = id_width(NUM_BTN)
) (
  input  logic [NUM_BTN-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    grant,
  output logic               any_req
);

  logic found;
  int   idx;

  // walk last_grant+1 .. last_grant+NUM_BTN modulo NUM_BTN, keep the first hit
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      idx = (int'(last_grant) + k) % NUM_BTN;
      if (!found && req[ID_W'(idx)]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/button_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// button_cmd_arbiter : queues button presses, issues them one at a time
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_cmd_arbiter
  import button_ctrl_pkg::*;
#(
  parameter int NUM_BTN     = 4,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                 clk_50MHz,
  input  logic                 rst,
  button_cmd_arbiter_if.slave  bus
);

  localparam int                ID_W      = id_width(NUM_BTN);
  localparam int                TMR_W     = $clog2(TIMEOUT_CYC + 1);
  localparam int                SUM_W     = DROP_W + 1;
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0]   GRANT_RST = ID_W'(NUM_BTN - 1);

  state_t             state, state_nxt;
  logic [NUM_BTN-1:0] pending, pending_nxt, clr_vec, drop_vec;
  logic [ID_W-1:0]    last_grant, last_grant_nxt;
  logic [ID_W-1:0]    cmd_id_r, cmd_id_nxt;
  logic               cmd_valid_r, cmd_valid_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               timeout_r, timeout_nxt;
  logic [DROP_W-1:0]  drop_r, drop_nxt;
  logic [SUM_W-1:0]   drop_sum;
  logic [ID_W-1:0]    rr_grant;
  logic               rr_any;
  logic               accept;
  logic               tmr_expire;

  rr_arbiter #(
    .NUM_BTN    (NUM_BTN),
    .ID_W       (ID_W)
  ) u_rr (
    .req        (pending),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .any_req    (rr_any)
  );

  assign accept     = (state == ST_ISSUE) && cmd_valid_r && bus.cmd_ready;
  assign tmr_expire = (timer == TMR_LAST);

  // a new press on the bit being cleared this cycle survives (set wins)
  assign clr_vec     = accept ? (NUM_BTN'(1) << cmd_id_r) : '0;
  assign drop_vec    = bus.btn_pulse & pending & ~clr_vec;
  assign pending_nxt = (pending & ~clr_vec) | bus.btn_pulse;

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending     <= '0;
      last_grant  <= GRANT_RST;
      cmd_id_r    <= '0;
      cmd_valid_r <= 1'b0;
      timer       <= '0;
      timeout_r   <= 1'b0;
      drop_r      <= '0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      last_grant  <= last_grant_nxt;
      cmd_id_r    <= cmd_id_nxt;
      cmd_valid_r <= cmd_valid_nxt;
      timer       <= timer_nxt;
      timeout_r   <= timeout_nxt;
      drop_r      <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (rr_any) state_nxt = ST_ISSUE;
      ST_ISSUE: if (accept) state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.op_done || tmr_expire) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid_nxt  = (state_nxt == ST_ISSUE);
    cmd_id_nxt     = ((state == ST_IDLE) && rr_any) ? rr_grant : cmd_id_r;
    last_grant_nxt = accept ? cmd_id_r : last_grant;
    timer_nxt      = (state == ST_WAIT) ? timer + TMR_W'(1) : '0;
    // op_done in the expiry cycle takes priority over the timeout
    timeout_nxt    = timeout_r | ((state == ST_WAIT) && !bus.op_done && tmr_expire);
    drop_sum       = SUM_W'(drop_r);
    for (int i = 0; i < NUM_BTN; i++) begin
      drop_sum = drop_sum + SUM_W'(drop_vec[i]);
    end
    drop_nxt = (drop_sum > SUM_W'(DROP_SAT)) ? DROP_SAT : drop_sum[DROP_W-1:0];
  end

  assign bus.busy        = (state != ST_IDLE);
  assign bus.cmd_valid   = cmd_valid_r;
  assign bus.cmd_id      = cmd_id_r;
  assign bus.timeout_err = timeout_r;
  assign bus.drop_cnt    = drop_r;

endmodule

`default_nettype wire

// File: tb/tb_button_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_button_cmd_arbiter : vector table, directed corner cases, random vs model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_button_cmd_arbiter;

  localparam int NB = 4;
  localparam int TO = 16;

  logic clk_50MHz = 1'b0;
  logic rst;

  button_cmd_arbiter_if #(.NUM_BTN(NB)) bus ();

  button_cmd_arbiter #(
    .NUM_BTN     (NB),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .bus       (bus.slave)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int rst;
    int btn;
    int rdy;
    int done;
    int exp_valid;
    int exp_id;
    int exp_busy;
    int exp_drop;
  } vec_t;

  vec_t vecs[$];

  // behavioural reference: phase 0=idle 1=issue 2=wait
  bit m_pend[NB];
  int m_phase, m_id, m_last, m_tmr, m_drop;
  bit m_terr;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic drive(input int r, input int b, input int rdy, input int d);
    rst           = r[0];
    bus.btn_pulse = b[NB-1:0];
    bus.cmd_ready = rdy[0];
    bus.op_done   = d[0];
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0);
  endtask

  function automatic void add(input int r, input int b, input int rdy, input int d,
                              input int ev, input int eid, input int eb, input int ed);
    vec_t v;
    v.rst = r; v.btn = b; v.rdy = rdy; v.done = d;
    v.exp_valid = ev; v.exp_id = eid; v.exp_busy = eb; v.exp_drop = ed;
    vecs.push_back(v);
  endfunction

  function automatic void model_step(input int r, input int b, input int rdy, input int d);
    bit acc;
    bit clr;
    bit np[NB];
    int w;
    if (r != 0) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_phase = 0; m_id = 0; m_last = NB - 1; m_tmr = 0; m_drop = 0; m_terr = 1'b0;
      return;
    end
    acc = (m_phase == 1) && (rdy != 0);
    for (int i = 0; i < NB; i++) begin
      clr = acc && (m_id == i);
      if (b[i] && m_pend[i] && !clr) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      np[i] = b[i] | (m_pend[i] & !clr);
    end
    case (m_phase)
      0: begin
        w = -1;
        for (int k = 1; k <= NB; k++)
          if (w < 0 && m_pend[(m_last + k) % NB]) w = (m_last + k) % NB;
        if (w >= 0) begin
          m_id = w;
          m_phase = 1;
        end
      end
      1: if (acc) begin
        m_last = m_id;
        m_tmr = 0;
        m_phase = 2;
      end
      default: begin
        if (d != 0) m_phase = 0;
        else if (m_tmr == TO - 1) begin
          m_terr = 1'b1;
          m_phase = 0;
        end else m_tmr++;
      end
    endcase
    m_pend = np;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1, 0, 0, 0);
    do_reset();

    check("reset valid", int'(bus.cmd_valid), 0);
    check("reset id", int'(bus.cmd_id), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset terr", int'(bus.timeout_err), 0);
    check("reset drop", int'(bus.drop_cnt), 0);

    // single press on button 2 with op_done seven cycles after the press
    add(0, 4, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 2, 1, 0);
    for (int r = 0; r < 4; r++) add(0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    // all four pressed together, served 0,1,2,3 with done 3 cycles after accept
    add(0, 15, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < NB; k++) begin
      add(0, 0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 1, k, 1, 0);
      add(0, 0, 1, 0, 0, 0, 1, 0);
      add(0, 0, 1, 0, 0, 0, 1, 0);
      add(0, 0, 1, 1, 0, 0, 1, 0);
    end
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].btn, vecs[i].rdy, vecs[i].done);
      check($sformatf("vec%0d valid", i), int'(bus.cmd_valid), vecs[i].exp_valid);
      if (vecs[i].exp_valid != 0)
        check($sformatf("vec%0d id", i), int'(bus.cmd_id), vecs[i].exp_id);
      check($sformatf("vec%0d busy", i), int'(bus.busy), vecs[i].exp_busy);
      check($sformatf("vec%0d drop", i), int'(bus.drop_cnt), vecs[i].exp_drop);
      tick();
    end

    // backpressure: held command stays stable, re-press is dropped
    do_reset();
    drive(0, 2, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
    for (int c = 0; c < 10; c++) begin
      check("bp valid", int'(bus.cmd_valid), 1);
      check("bp id", int'(bus.cmd_id), 1);
      bus.btn_pulse = (c == 4) ? 4'b0010 : 4'b0000;
      tick();
    end
    check("bp drop", int'(bus.drop_cnt), 1);
    check("bp still valid", int'(bus.cmd_valid), 1);
    drive(0, 0, 1, 0); tick();
    check("bp accepted valid", int'(bus.cmd_valid), 0);
    check("bp wait busy", int'(bus.busy), 1);
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
    check("bp done busy", int'(bus.busy), 0);
    tick();
    check("bp no reissue", int'(bus.busy), 0);

    // timeout after 16 wait cycles, then the queued request is still served
    do_reset();
    drive(0, 1, 1, 0); tick();
    drive(0, 0, 1, 0); tick();
    check("to issue id", int'(bus.cmd_id), 0);
    tick();
    bus.btn_pulse = 4'b0100;
    check("to wait busy", int'(bus.busy), 1);
    tick();
    bus.btn_pulse = 4'b0000;
    for (int w = 1; w < 15; w++) begin
      check("to early terr", int'(bus.timeout_err), 0);
      tick();
    end
    check("to last wait terr", int'(bus.timeout_err), 0);
    check("to last wait busy", int'(bus.busy), 1);
    tick();
    check("to terr set", int'(bus.timeout_err), 1);
    check("to idle", int'(bus.busy), 0);
    tick();
    check("to next valid", int'(bus.cmd_valid), 1);
    check("to next id", int'(bus.cmd_id), 2);
    tick();
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
    check("to terr sticky", int'(bus.timeout_err), 1);

    // reset while waiting with buttons 1 and 3 pending
    do_reset();
    drive(0, 4, 1, 0); tick();
    drive(0, 0, 1, 0); tick(); tick();
    drive(0, 10, 0, 0); tick(); tick();
    drive(1, 0, 0, 0);
    check("mid pre drop", int'(bus.drop_cnt), 2);
    check("mid pre busy", int'(bus.busy), 1);
    tick();
    drive(0, 0, 0, 0);
    check("mid rst valid", int'(bus.cmd_valid), 0);
    check("mid rst id", int'(bus.cmd_id), 0);
    check("mid rst busy", int'(bus.busy), 0);
    check("mid rst drop", int'(bus.drop_cnt), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mid pend cleared", int'(bus.busy), 0);
    end
    drive(0, 10, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
    check("mid next valid", int'(bus.cmd_valid), 1);
    check("mid next id", int'(bus.cmd_id), 1);

    // drop counter saturation
    do_reset();
    drive(0, 1, 0, 0); tick();
    for (int c = 0; c < 255; c++) tick();
    check("sat at 255", int'(bus.drop_cnt), 255);
    for (int c = 0; c < 45; c++) tick();
    drive(0, 0, 0, 0); tick();
    check("sat no wrap", int'(bus.drop_cnt), 255);

    // randomized traffic against the reference model
    do_reset();
    model_step(1, 0, 0, 0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int b, rdy, d, r, rate;
      check($sformatf("rnd%0d valid", cyc), int'(bus.cmd_valid), (m_phase == 1) ? 1 : 0);
      if (m_phase == 1) check($sformatf("rnd%0d id", cyc), int'(bus.cmd_id), m_id);
      check($sformatf("rnd%0d busy", cyc), int'(bus.busy), (m_phase != 0) ? 1 : 0);
      check($sformatf("rnd%0d terr", cyc), int'(bus.timeout_err), int'(m_terr));
      check($sformatf("rnd%0d drop", cyc), int'(bus.drop_cnt), m_drop);
      rate = ((cyc / 500) % 2 == 0) ? 4 : 24;
      b = 0;
      for (int i = 0; i < NB; i++) if ($urandom_range(0, 5) == 0) b = b | (1 << i);
      rdy = int'($urandom_range(0, 1));
      d = ($urandom_range(0, rate - 1) == 0) ? 1 : 0;
      r = ($urandom_range(0, 399) == 0) ? 1 : 0;
      drive(r, b, rdy, d);
      model_step(r, b, rdy, d);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
